// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing datapath: default widths
// used by the number generator, the adder and the stream decoder, plus the
// decoder's state encoding.
package sc_pkg;

    // log2 of the decoding window (window = 256 valid stream bits)
    localparam int SC_LEN_W = 8;
    // Width of the nummax scale and of the decoded binary value
    localparam int SC_NUM_W = 9;

    // Stream decoder control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_SCALE = 2'd2,
        ST_DONE  = 2'd3
    } sc_state_e;

    // Even parity over a sample/ones counter value, available to checkers
    // that want a cheap integrity signature of the window state.
    function automatic logic cnt_parity(input logic [SC_LEN_W:0] val);
        cnt_parity = ^val;
    endfunction

endpackage

// File: rtl/sc_window_counter.sv
// Window counter for the stream decoder: counts valid samples and the ones
// among them over a window of 2^LEN_W valid bits. The sample counter is one
// bit wider than the window index so it can hold the full window size and
// never wraps; once the window is full further enables are ignored.
module sc_window_counter
    import sc_pkg::*;
#(
    parameter int LEN_W = SC_LEN_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             sample_en_i,
    input  logic             bit_i,
    output logic [LEN_W:0]   ones_o,
    output logic             window_done_o
);

    localparam logic [LEN_W:0] CNT_ZERO    = {(LEN_W+1){1'b0}};
    localparam logic [LEN_W:0] CNT_ONE     = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0] LAST_SAMPLE = {1'b0, {LEN_W{1'b1}}};

    logic [LEN_W:0] samples_q;
    logic [LEN_W:0] samples_d;
    logic [LEN_W:0] ones_q;
    logic [LEN_W:0] ones_d;

    // Next-state of the counters: clear wins, otherwise count accepted samples
    always_comb begin
        samples_d = samples_q;
        ones_d    = ones_q;
        if (clear_i) begin
            samples_d = CNT_ZERO;
            ones_d    = CNT_ZERO;
        end else if (sample_en_i && !samples_q[LEN_W]) begin
            samples_d = samples_q + CNT_ONE;
            ones_d    = ones_q + {{LEN_W{1'b0}}, bit_i};
        end else begin
            samples_d = samples_q;
            ones_d    = ones_q;
        end
    end

    // Counter registers, cleared by the asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            samples_q <= CNT_ZERO;
            ones_q    <= CNT_ZERO;
        end else begin
            samples_q <= samples_d;
            ones_q    <= ones_d;
        end
    end

    assign ones_o = ones_q;

    // High in the cycle whose sample completes the window
    assign window_done_o = sample_en_i && (samples_q == LAST_SAMPLE);

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary stream decoder. After an accepted start it counts the
// ones in the next 2^LEN_W valid stream bits, multiplies that count by the
// nummax latched at start, and presents count and ones*nummax/2^LEN_W with a
// one-cycle done pulse. The product register doubles as the value holding
// register, so value appears in the same cycle as done and holds until the
// next conversion completes.
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int LEN_W = SC_LEN_W,
    parameter int NUM_W = SC_NUM_W
) (
    input  logic             clkB,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] nummax_in,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [LEN_W:0]   count,
    output logic [NUM_W-1:0] value
);

    localparam int PROD_W = LEN_W + 1 + NUM_W;

    sc_state_e          state_q;
    logic [NUM_W-1:0]   nummax_q;
    logic [PROD_W-1:0]  product_q;
    logic [LEN_W:0]     count_q;
    logic               busy_q;
    logic               done_q;

    logic               clear_s;
    logic               sample_en_s;
    logic [LEN_W:0]     ones_s;
    logic               window_done_s;
    logic [PROD_W-1:0]  product_s;

    // Counter control: clear on an accepted start, count only while accumulating
    always_comb begin
        clear_s     = 1'b0;
        sample_en_s = 1'b0;
        if (state_q == ST_IDLE) begin
            clear_s = start;
        end else if (state_q == ST_ACC) begin
            sample_en_s = bit_valid;
        end else begin
            clear_s     = 1'b0;
            sample_en_s = 1'b0;
        end
    end

    sc_window_counter #(
        .LEN_W (LEN_W)
    ) u_window (
        .clk_i         (clkB),
        .rst_i         (rst),
        .clear_i       (clear_s),
        .sample_en_i   (sample_en_s),
        .bit_i         (bit_in),
        .ones_o        (ones_s),
        .window_done_o (window_done_s)
    );

    // Scaling multiply, full width so no product bit is lost
    always_comb begin
        product_s = PROD_W'(ones_s) * PROD_W'(nummax_q);
    end

    // Control FSM with registered busy/done/count and the product pipeline register
    always_ff @(posedge clkB or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            nummax_q  <= {NUM_W{1'b0}};
            product_q <= {PROD_W{1'b0}};
            count_q   <= {(LEN_W+1){1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        nummax_q <= nummax_in;
                        busy_q   <= 1'b1;
                        state_q  <= ST_ACC;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACC: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b1;
                    if (window_done_s) begin
                        state_q <= ST_SCALE;
                    end else begin
                        state_q <= ST_ACC;
                    end
                end
                ST_SCALE: begin
                    product_q <= product_s;
                    count_q   <= ones_s;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;
    // ones <= 2^LEN_W, so the shifted product always fits in NUM_W bits
    assign value = NUM_W'(product_q >> LEN_W);

endmodule

// File: doc/sc_stream_decoder.md
Name: sc_stream_decoder

Overview:
- Downstream consumer of the stochastic adder's output pair: the bitstream `c` and the scale `newnummax`.
- Counts the ones in a fixed window of 2^LEN_W valid stream bits.
- Converts that count back to binary magnitude: value = ones / 2^LEN_W * nummax.
- Sits at the stochastic-to-binary boundary of the datapath, with a start/busy/done handshake toward the controlling logic.

Parameters:
- LEN_W, 8, log2 of window length; window = 2^LEN_W valid bits (256).
- NUM_W, 9, width of the nummax scale input and of the value output.

Ports:
- clkB  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new conversion; honoured only in IDLE.
- nummax_in  input  NUM_W  scale of the incoming stream; latched on accepted start.
- bit_in  input  1  stochastic stream bit (adder `c`).
- bit_valid  input  1  bit_in is a sample this cycle.
- busy  output  1  high in ACC and SCALE.
- done  output  1  one-cycle pulse when results update.
- count  output  LEN_W+1  ones counted in last window, range 0..2^LEN_W.
- value  output  NUM_W  scaled binary result.

Behaviour:
- Reset:
  - Asserting rst forces state IDLE at any time, including mid-window. The partial window is discarded.
  - On reset, busy=0, done=0, count=0, value=0, and internal sample counter, ones counter and latched nummax are all cleared.
- States: IDLE, ACC, SCALE, DONE.
- IDLE:
  - If start=1: latch nummax_in, clear ones and sample counters, go to ACC.
  - bit_in is not sampled in the start cycle.
- ACC:
  - Each cycle with bit_valid=1: sample counter +1, and ones counter +bit_in.
  - Cycles with bit_valid=0 change nothing and the window stretches.
  - When the 2^LEN_W-th valid sample is taken, go to SCALE.
  - The sample counter is LEN_W+1 bits and never wraps within a window.
- SCALE (1 cycle): compute product = ones * nummax_latched, width LEN_W+1+NUM_W, into a pipeline register.
- DONE (1 cycle):
  - count <= ones; value <= product >> LEN_W, truncated toward zero.
  - done=1 for this cycle only, then return to IDLE.
- value ≤ nummax_latched by construction, so no saturation logic is required.
- count and value hold until the next DONE or reset.
- start is ignored in ACC, SCALE and DONE: no queuing, no restart. start in the cycle after DONE (IDLE) is accepted, giving back-to-back conversions.
- bit_in and bit_valid are ignored outside ACC.
- Latency with bit_valid held high: start at cycle 0, samples in cycles 1..256, SCALE at 257, done=1 and new outputs visible at 258.

Decomposition:
- Shared package sc_pkg holds:
  - the state enum typedef (IDLE, ACC, SCALE, DONE);
  - the default LEN_W and NUM_W constants, reused by the number generator and the adder.
- One natural sub-module: sc_window_counter, holding the sample and ones counters, a clear input, a sample-enable input, and a window-complete flag. The FSM and the scaling stay in the top module.

Test Plan:
- All ones: nummax_in=300, bit_in=1 and bit_valid=1 for 256 cycles → done at cycle 258, count=256, value=300.
- All zeros: nummax_in=511, bit_in=0 throughout → count=0, value=0.
- Alternating 1/0: nummax_in=200 → count=128, value=100. Then 3 ones in 256 with nummax_in=100 → count=3, value=1 (truncation of 300/256).
- bit_valid gaps: valid every other cycle, stream all ones, nummax_in=10 → done at cycle 514, count=256, value=10. busy high from cycle 1 through 513.
- Protocol: start held high throughout → start ignored while busy, done pulses exactly once per window, new conversion begins the cycle after DONE. nummax_in changed mid-window → result uses the latched value.
- Reset mid-ACC: assert rst at sample 100 → busy=0, count=0, value=0 immediately. A fresh start then yields a correct full 256-sample result.
